// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor around a single 1-bit FA/FS slice.
// Operands are consumed LSB-first, one bit per clock, under a start/busy/done handshake.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dec,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dec_q, dec_d;
  logic             c_q, c_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic x;
  logic y;
  logic s;
  logic c_nx;
  logic last;

  // One FA/FS slice; dec selects borrow vs carry generation.
  always_comb begin
    x    = a_q[0];
    y    = b_q[0];
    s    = x ^ y ^ c_q;
    c_nx = dec_q ? ((~x & y) | (~(x ^ y) & c_q))
                 : ((x & y) | (c_q & (x ^ y)));
    last = (cnt_q == LAST);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    dec_d   = dec_q;
    c_d     = c_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          dec_d   = dec;
          c_d     = bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = {s, res_q[WIDTH-1:1]};
        c_d   = c_nx;
        if (last) begin
          // Signed overflow: carry into MSB differs from carry out.
          bout_d  = c_nx;
          ovf_d   = c_q ^ c_nx;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      dec_q   <= 1'b0;
      c_q     <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      dec_q   <= dec_d;
      c_q     <= c_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = res_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub at WIDTH=8.
// Expected values are hand-computed constants.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         dec;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         bout;
  logic         overflow;

  int checks;
  int failures;

  serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dec      (dec),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .bout     (bout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {20'd0, busy, done, result, bout, overflow};
  endfunction

  task automatic start_op(input logic d,
                          input logic [W-1:0] av,
                          input logic [W-1:0] bv,
                          input logic bi);
    dec   = d;
    a     = av;
    b     = bv;
    bin   = bi;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 8'hC3;
    b     = 8'h3C;
    bin   = ~bi;
  endtask

  // n counts edges including the one that sampled start.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag,
                        input logic d,
                        input logic [W-1:0] av,
                        input logic [W-1:0] bv,
                        input logic bi,
                        input logic [W-1:0] er,
                        input logic eb,
                        input logic eo);
    int n;
    start_op(d, av, bv, bi);
    chk({tag, "_busy"}, busy, 1);
    wait_done(n);
    chk({tag, "_lat"}, n, W + 1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_bout"}, bout, eb);
    chk({tag, "_ovf"}, overflow, eo);
    tick();
    chk({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int n;
    int dcnt;
    int np;
    int t[4];
    bit seen;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    start    = 1'b0;
    dec      = 1'b0;
    a        = '0;
    b        = '0;
    bin      = 1'b0;

    // 1: reset and idle
    #3 rst_n = 1'b0;
    #1 chk("rst_outs", outs(), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_hold", outs(), 0);
    end

    // 2: basic subtract
    run_op("sub_basic", 1, 8'h35, 8'h12, 0, 8'h23, 0, 0);

    // 3: subtract boundaries
    run_op("sub_wrap", 1, 8'h10, 8'h20, 0, 8'hF0, 1, 0);
    run_op("sub_ovf", 1, 8'h80, 8'h01, 0, 8'h7F, 0, 1);
    run_op("sub_bin", 1, 8'h00, 8'h00, 1, 8'hFF, 1, 0);

    // 4: add mode
    run_op("add_ovf", 0, 8'h7F, 8'h01, 0, 8'h80, 0, 1);
    run_op("add_wrap", 0, 8'hFF, 8'h01, 0, 8'h00, 1, 0);
    run_op("add_cin", 0, 8'h0F, 8'hF0, 1, 8'h00, 1, 0);

    // 5: start ignored during RUN and DONE
    start_op(1, 8'h35, 8'h12, 0);
    dcnt = 0;
    for (int i = 1; i <= 25; i++) begin
      start = (i == 3 || i == 9);
      dec   = 1'b0;
      a     = 8'hAA;
      b     = 8'h55;
      tick();
      if (done) begin
        dcnt++;
        chk("hs_res", result, 8'h23);
        chk("hs_edge", i, 8);
      end
    end
    start = 1'b0;
    chk("hs_pulses", dcnt, 1);
    chk("hs_idle", busy, 0);

    // 5b: start held high
    dec   = 1'b1;
    a     = 8'h35;
    b     = 8'h12;
    bin   = 1'b0;
    start = 1'b1;
    np    = 0;
    for (int k = 0; k < 4; k++) t[k] = -100;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (done) begin
        if (np < 4) t[np] = i;
        np++;
        chk("b2b_res", result, 8'h23);
      end
    end
    start = 1'b0;
    chk("b2b_count", np, 4);
    chk("b2b_gap0", t[1] - t[0], 10);
    chk("b2b_gap1", t[2] - t[1], 10);
    chk("b2b_gap2", t[3] - t[2], 10);
    wait_done(n);
    tick();
    chk("b2b_idle", busy, 0);

    // 6: reset mid-operation
    start_op(1, 8'h35, 8'h12, 0);
    tick();
    tick();
    tick();
    chk("abort_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1 chk("abort_outs", outs(), 0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 1) rst_n = 1'b1;
      if (done) seen = 1'b1;
    end
    chk("abort_nodone", seen, 0);
    chk("abort_idle", outs(), 0);
    run_op("post_rst", 1, 8'h50, 8'h05, 0, 8'h4B, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
